core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
- Shares one core-side data bus (req/gnt/rvalid protocol) between NB_MASTERS requesters, e.g. instruction fetch, data port and debug, in front of the core-to-AXI bridge.
- Round-robin arbitration, with the selection locked while a request is stalled so that downstream AXI valid/address stay stable.
- An owner FIFO tracks outstanding transactions and routes each rvalid/rdata back to the master that issued it.

Parameters:
- NB_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, address width on all ports.
- MAX_OUTSTANDING, 2, owner FIFO depth, i.e. maximum number of granted-but-unanswered transactions (1..4).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_req_i  in  NB_MASTERS  per-master request.
- m_gnt_o  out  NB_MASTERS  per-master grant.
- m_rvalid_o  out  NB_MASTERS  per-master response valid.
- m_addr_i  in  NB_MASTERS x ADDR_WIDTH  per-master address.
- m_we_i  in  NB_MASTERS  per-master write enable.
- m_be_i  in  NB_MASTERS x 4  per-master byte enables.
- m_wdata_i  in  NB_MASTERS x 32  per-master write data.
- m_rdata_o  out  32  shared read data; valid only for the master whose m_rvalid_o is high.
- s_req_o  out  1  request to bridge.
- s_gnt_i  in  1  grant from bridge.
- s_rvalid_i  in  1  response valid from bridge.
- s_addr_o  out  ADDR_WIDTH  muxed address.
- s_we_o  out  1  muxed write enable.
- s_be_o  out  4  muxed byte enables.
- s_wdata_o  out  32  muxed write data.
- s_rdata_i  in  32  read data from bridge.
- err_o  out  1  sticky: s_rvalid_i arrived while the owner FIFO was empty.

Behaviour:
- Reset values:
  - rr_ptr=0, lock_q=0, lock_idx_q=0, FIFO empty, err_o=0.
  - All grant/rvalid outputs and s_req_o are 0. They are combinational but gated low by an empty or idle state.
- Selection when lock_q=0: round-robin starting at rr_ptr. Pick the first index i in (rr_ptr, rr_ptr+1, ..., wrap mod NB_MASTERS) with m_req_i[i]=1.
- Selection when lock_q=1: sel = lock_idx_q, regardless of the other requests.
- Forwarding:
  - can_issue = !fifo_full || s_rvalid_i (a simultaneous pop frees a slot).
  - s_req_o = can_issue && m_req_i[sel].
  - s_addr/we/be/wdata are driven from master sel.
- Grant: m_gnt_o[sel] = s_gnt_i && s_req_o, in the same cycle (zero added latency). All other bits are 0.
- On grant:
  - push sel into the owner FIFO;
  - rr_ptr <= (sel+1) mod NB_MASTERS;
  - lock_q <= 0.
- Stall: if s_req_o=1 and s_gnt_i=0, then lock_q <= 1 and lock_idx_q <= sel. The lock holds until that master is granted.
- Lock release without grant: if the locked master drops m_req_i (a protocol violation), lock_q <= 0 on the next edge. No push occurs.
- Response: on s_rvalid_i with FIFO non-empty:
  - m_rvalid_o[head]=1 and m_rdata_o=s_rdata_i in the same cycle;
  - pop the FIFO.
- Response with FIFO empty: s_rvalid_i is dropped, no m_rvalid_o is asserted, and err_o <= 1 (sticky until reset).
- Push and pop in the same cycle: both occur and the FIFO count is unchanged. Pop-then-push ordering is observable when the FIFO is full.
- Full FIFO without s_rvalid_i: s_req_o=0, no grant, and rr_ptr/lock_q are unchanged.
- Reset asserted mid-transaction: everything clears immediately. Outstanding responses arriving after reset set err_o.

Optional Feature:
- Macro: CORE_ARB_PERF_CNT_EN.
- Defined:
  - adds output perf_gnt_cnt_o, NB_MASTERS x 32;
  - adds input perf_clr_i, 1;
  - per-master grant counters increment on m_gnt_o[i], wrap at 2^32, reset to 0, and clear synchronously on perf_clr_i (clear wins over increment).
- Undefined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Package core_arb_pkg:
  - localparam function idx_width(n) = max(1, $clog2(n));
  - typedef for the master index;
  - typedef struct req_t {addr, we, be, wdata} used for the muxes.
- Sub-module arb_owner_fifo: parameterised DEPTH and WIDTH; push/pop/full/empty/head; pop before push; count register.

Test Plan:
- Two masters request continuously; the bridge grants every cycle. Grants alternate 0,1,0,1. rvalid 2 cycles later routes to the correct master with rdata 0xA5A5_0000 and 0x5A5A_0001 respectively.
- Master 1 requests with s_gnt_i held low for 5 cycles, and master 0 raises req at cycle 2. s_addr_o stays at master 1's address 0x1000_0040 for all 5 cycles; master 1 is granted first.
- MAX_OUTSTANDING=2; two grants issued with no rvalid. A third request sees s_req_o=0. Driving s_rvalid_i in that cycle forwards the request and grants it in the same cycle.
- s_rvalid_i pulsed with the FIFO empty: no m_rvalid_o is asserted, err_o=1 and stays 1 until rst_ni is low.
- rst_ni pulsed low with 2 outstanding transactions: FIFO count=0, rr_ptr=0 and all outputs 0 immediately. The next grant goes to master 0.
- With CORE_ARB_PERF_CNT_EN: 10 grants to master 0 and 3 to master 1 give counts 10 and 3. perf_clr_i then gives 0 and 0.

Source files
------------

// File: rtl/core_arb_pkg.sv
// Shared types and helpers for the core bus arbiter.
// Optional grant counters are enabled with the CORE_ARB_PERF_CNT_EN macro
// (see core_bus_arbiter.sv).
package core_arb_pkg;

    // Upper bounds of the supported configuration range.
    localparam int MAX_MASTERS = 8;
    localparam int MAX_ADDR_W  = 64;

    // Width of a master index; never zero so a single-bit index always exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Master index wide enough for the largest supported configuration.
    typedef logic [$clog2(MAX_MASTERS)-1:0] master_idx_t;

    // One master's request payload as seen by the output mux. The address is
    // held at the maximum width and zero-extended from the configured width.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
    } req_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: records which master issued each granted transaction so the
// in-order responses can be routed back. A pop and a push in the same cycle
// are both honoured, even when full (the pop frees the slot first).
module arb_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop, do_push;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];

    // Next-state of pointers and occupancy.
    always_comb begin
        rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one core-side req/gnt/rvalid bus between
// NB_MASTERS requesters. A stalled request locks the selection so the
// downstream address/data stay stable until granted. Responses are routed
// back in order via an owner FIFO.
// Optional: define CORE_ARB_PERF_CNT_EN to add per-master grant counters
// (perf_gnt_cnt_o) with a synchronous clear (perf_clr_i).
module core_bus_arbiter
    import core_arb_pkg::*;
#(
    parameter int NB_MASTERS      = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_MASTERS-1:0]                m_req_i,
    output logic [NB_MASTERS-1:0]                m_gnt_o,
    output logic [NB_MASTERS-1:0]                m_rvalid_o,
    input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NB_MASTERS-1:0]                m_we_i,
    input  logic [NB_MASTERS-1:0][3:0]           m_be_i,
    input  logic [NB_MASTERS-1:0][31:0]          m_wdata_i,
    output logic [31:0]                          m_rdata_o,
    output logic                                 s_req_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [3:0]                           s_be_o,
    output logic [31:0]                          s_wdata_o,
    input  logic [31:0]                          s_rdata_i,
`ifdef CORE_ARB_PERF_CNT_EN
    input  logic                                 perf_clr_i,
    output logic [NB_MASTERS-1:0][31:0]          perf_gnt_cnt_o,
`endif
    output logic                                 err_o
);

    localparam int IDX_W = idx_width(NB_MASTERS);

    if (NB_MASTERS < 2 || NB_MASTERS > MAX_MASTERS) begin : g_bad_nb
        $error("core_bus_arbiter: NB_MASTERS out of range");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_depth
        $error("core_bus_arbiter: MAX_OUTSTANDING out of range");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > MAX_ADDR_W) begin : g_bad_aw
        $error("core_bus_arbiter: ADDR_WIDTH out of range");
    end

    // Arbitration state.
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             err_q, err_d;

    // Datapath / handshake signals.
    logic [IDX_W-1:0] sel;
    req_t             req_arr [NB_MASTERS];
    req_t             sel_req;
    logic             fifo_full, fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    logic             can_issue;
    logic             grant;
    logic             rsp_pop;
    logic             unused_addr_hi;

    // Wrap-around successor of a master index.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NB_MASTERS - 1)) ? '0 : i + 1'b1;
    endfunction

    // Gather each master's payload into the common request type.
    always_comb begin
        for (int i = 0; i < NB_MASTERS; i++) begin
            req_arr[i].addr  = MAX_ADDR_W'(m_addr_i[i]);
            req_arr[i].we    = m_we_i[i];
            req_arr[i].be    = m_be_i[i];
            req_arr[i].wdata = m_wdata_i[i];
        end
    end

    // Master selection: the locked master wins, otherwise the first requester
    // at or after rr_ptr_q. With no requester sel is irrelevant (s_req_o=0).
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        sel   = rr_ptr_q;
        found = 1'b0;
        cand  = rr_ptr_q;
        for (int k = 0; k < NB_MASTERS; k++) begin
            if (!found && m_req_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = next_idx(cand);
        end
        if (lock_q) begin
            sel = lock_idx_q;
        end
    end

    // A response arriving this cycle frees a slot, so a full FIFO can still issue.
    assign can_issue = !fifo_full || s_rvalid_i;
    assign s_req_o   = can_issue && m_req_i[sel];
    assign grant     = s_req_o && s_gnt_i;
    assign rsp_pop   = s_rvalid_i && !fifo_empty;

    assign sel_req   = req_arr[sel];
    assign s_addr_o  = sel_req.addr[ADDR_WIDTH-1:0];
    assign s_we_o    = sel_req.we;
    assign s_be_o    = sel_req.be;
    assign s_wdata_o = sel_req.wdata;
    // Zero-extension bits above ADDR_WIDTH carry no information.
    assign unused_addr_hi = ^(sel_req.addr >> ADDR_WIDTH);

    // Same-cycle grant and response routing, one-hot on the chosen master.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (grant) begin
            m_gnt_o[sel] = 1'b1;
        end
        if (rsp_pop) begin
            m_rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    // Next-state: grant advances the pointer and releases the lock; a stall
    // locks the current selection; a locked master dropping its request
    // releases the lock without any push.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q || (s_rvalid_i && fifo_empty);
        if (grant) begin
            rr_ptr_d = next_idx(sel);
            lock_d   = 1'b0;
        end else if (s_req_o && !s_gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (lock_q && !m_req_i[lock_idx_q]) begin
            lock_d = 1'b0;
        end
    end

    // Arbitration and error state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (rsp_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef CORE_ARB_PERF_CNT_EN
    logic [NB_MASTERS-1:0][31:0] perf_cnt_q;

    // Per-master grant counters, wrapping; clear has priority over a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_q <= '0;
        end else if (perf_clr_i) begin
            perf_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NB_MASTERS; i++) begin
                if (m_gnt_o[i]) begin
                    perf_cnt_q[i] <= perf_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign perf_gnt_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Testbench for core_bus_arbiter: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_core_bus_arbiter;

    localparam int NB   = 2;
    localparam int AW   = 32;
    localparam int MAXO = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NB-1:0]        m_req, m_we, m_gnt, m_rvalid;
    logic [NB-1:0][AW-1:0] m_addr;
    logic [NB-1:0][3:0]   m_be;
    logic [NB-1:0][31:0]  m_wdata;
    logic [31:0]          m_rdata, s_wdata, s_rdata;
    logic                 s_req, s_gnt, s_rvalid, s_we, err;
    logic [AW-1:0]        s_addr;
    logic [3:0]           s_be;
`ifdef CORE_ARB_PERF_CNT_EN
    logic                 perf_clr = 1'b0;
    logic [NB-1:0][31:0]  perf_cnt;
    int unsigned          perf_m [NB];
`endif

    always #5 clk = ~clk;

    core_bus_arbiter #(
        .NB_MASTERS      (NB),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .m_req_i        (m_req),
        .m_gnt_o        (m_gnt),
        .m_rvalid_o     (m_rvalid),
        .m_addr_i       (m_addr),
        .m_we_i         (m_we),
        .m_be_i         (m_be),
        .m_wdata_i      (m_wdata),
        .m_rdata_o      (m_rdata),
        .s_req_o        (s_req),
        .s_gnt_i        (s_gnt),
        .s_rvalid_i     (s_rvalid),
        .s_addr_o       (s_addr),
        .s_we_o         (s_we),
        .s_be_o         (s_be),
        .s_wdata_o      (s_wdata),
        .s_rdata_i      (s_rdata),
`ifdef CORE_ARB_PERF_CNT_EN
        .perf_clr_i     (perf_clr),
        .perf_gnt_cnt_o (perf_cnt),
`endif
        .err_o          (err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: owners of outstanding transactions, in issue order.
    int q[$];
    int rr;
    bit lock;
    int lidx;
    bit err_m;
    // Effects of the current cycle, applied at the next clock edge.
    bit n_pop, n_push, n_lock, n_err;
    int n_sel, n_rr, n_lidx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0; lock = 0; lidx = 0; err_m = 0;
`ifdef CORE_ARB_PERF_CNT_EN
        for (int i = 0; i < NB; i++) perf_m[i] = 0;
`endif
    endtask

    // Let inputs settle, predict this cycle's outputs and compare.
    task automatic eval();
        int sel;
        bit found, can, sreq, g, pop;
        logic [NB-1:0] eg, er;
        #1;
        sel = rr;
        found = 0;
        if (lock) sel = lidx;
        else begin
            for (int k = 0; k < NB; k++) begin
                if (!found && m_req[(rr + k) % NB]) begin
                    sel = (rr + k) % NB;
                    found = 1;
                end
            end
        end
        pop  = s_rvalid && (q.size() > 0);
        can  = (q.size() < MAXO) || s_rvalid;
        sreq = can && m_req[sel];
        g    = sreq && s_gnt;
        eg = '0; if (g) eg[sel] = 1'b1;
        er = '0; if (pop) er[q[0]] = 1'b1;
        chk("s_req", s_req, sreq);
        chk("m_gnt", m_gnt, eg);
        chk("m_rvalid", m_rvalid, er);
        if (sreq) begin
            chk("s_addr", s_addr, m_addr[sel]);
            chk("s_we", s_we, m_we[sel]);
            chk("s_be", s_be, m_be[sel]);
            chk("s_wdata", s_wdata, m_wdata[sel]);
        end
        if (pop) chk("m_rdata", m_rdata, s_rdata);
        n_pop  = pop;
        n_push = g;
        n_sel  = sel;
        n_err  = err_m || (s_rvalid && q.size() == 0);
        n_rr   = g ? (sel + 1) % NB : rr;
        n_lock = lock;
        n_lidx = lidx;
        if (g) n_lock = 0;
        else if (sreq && !s_gnt) begin n_lock = 1; n_lidx = sel; end
        else if (lock && !m_req[lidx]) n_lock = 0;
    endtask

    // Advance across a clock edge and check registered outputs.
    task automatic commit();
        @(posedge clk);
        if (n_pop) void'(q.pop_front());
        if (n_push) q.push_back(n_sel);
        rr = n_rr; lock = n_lock; lidx = n_lidx; err_m = n_err;
`ifdef CORE_ARB_PERF_CNT_EN
        if (perf_clr) begin
            for (int i = 0; i < NB; i++) perf_m[i] = 0;
        end else if (n_push) perf_m[n_sel]++;
`endif
        #1;
        chk("err", err, err_m);
`ifdef CORE_ARB_PERF_CNT_EN
        for (int i = 0; i < NB; i++) chk("perf_cnt", perf_cnt[i], perf_m[i]);
`endif
    endtask

    task automatic step();
        eval();
        commit();
    endtask

    task automatic idle_inputs();
        m_req = '0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        m_we = '0; m_be = '0; m_wdata = '0; m_addr = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_s_req", s_req, 1'b0);
        chk("rst_m_gnt", m_gnt, 2'b00);
        chk("rst_m_rvalid", m_rvalid, 2'b00);
        chk("rst_err", err, 1'b0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Alternating grants with responses two cycles later
        m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200;
        m_we = 2'b10; m_be[0] = 4'hF; m_be[1] = 4'h3;
        m_wdata[0] = 32'h1111_1111; m_wdata[1] = 32'h2222_2222;
        m_req = 2'b11; s_gnt = 1;
        eval(); chk("alt_g0", m_gnt, 2'b01); commit();
        eval(); chk("alt_g1", m_gnt, 2'b10); commit();
        s_rvalid = 1; s_rdata = 32'hA5A5_0000;
        eval(); chk("alt_rv0", m_rvalid, 2'b01); chk("alt_rd0", m_rdata, 32'hA5A5_0000);
        chk("alt_g2", m_gnt, 2'b01); commit();
        s_rdata = 32'h5A5A_0001;
        eval(); chk("alt_rv1", m_rvalid, 2'b10); chk("alt_rd1", m_rdata, 32'h5A5A_0001);
        chk("alt_g3", m_gnt, 2'b10); commit();
        m_req = '0; s_gnt = 0;
        step(); step();
        s_rvalid = 0;

        // Stalled master 1 keeps the bus while master 0 joins
        m_addr[1] = 32'h1000_0040; m_addr[0] = 32'h2000_0000;
        m_req = 2'b10; s_gnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) m_req = 2'b11;
            eval();
            chk("stall_addr", s_addr, 32'h1000_0040);
            chk("stall_gnt", m_gnt, 2'b00);
            commit();
        end
        s_gnt = 1;
        eval(); chk("stall_first", m_gnt, 2'b10); commit();
        eval(); chk("stall_second", m_gnt, 2'b01); commit();
        m_req = '0; s_gnt = 0; s_rvalid = 1;
        step(); step();
        s_rvalid = 0;

        // Full owner FIFO, released by a same-cycle response
        m_req = 2'b11; s_gnt = 1;
        step(); step();
        eval(); chk("full_sreq", s_req, 1'b0); chk("full_gnt", m_gnt, 2'b00);
        s_rvalid = 1; s_rdata = 32'hCAFE_0001;
        eval(); chk("full_fwd", s_req, 1'b1); chk("full_gnt_rv", m_gnt, 2'b10);
        chk("full_rv", m_rvalid, 2'b10); commit();
        m_req = '0; s_gnt = 0;
        step(); step();
        s_rvalid = 0;

        // Response with nothing outstanding
        s_rvalid = 1;
        eval(); chk("orphan_rv", m_rvalid, 2'b00); commit();
        chk("orphan_err", err, 1'b1);
        s_rvalid = 0;
        repeat (3) step();
        chk("err_sticky", err, 1'b1);

        // Reset with two outstanding transactions
        m_req = 2'b11; s_gnt = 1;
        step(); step();
        m_req = '0; s_gnt = 0; s_rvalid = 1;
        #1 rst_n = 0;
        #1;
        chk("rst_mid_rv", m_rvalid, 2'b00);
        chk("rst_mid_gnt", m_gnt, 2'b00);
        chk("rst_mid_sreq", s_req, 1'b0);
        chk("rst_mid_err", err, 1'b0);
        @(posedge clk);
        #2 s_rvalid = 0; rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        s_rvalid = 1;
        eval(); chk("late_rv", m_rvalid, 2'b00); commit();
        chk("late_err", err, 1'b1);
        s_rvalid = 0; m_req = 2'b11; s_gnt = 1;
        eval(); chk("post_rst_gnt", m_gnt, 2'b01); commit();
        m_req = '0; s_gnt = 0; s_rvalid = 1;
        step();
        s_rvalid = 0;
        do_reset();

`ifdef CORE_ARB_PERF_CNT_EN
        // Grant counters and clear
        s_gnt = 1;
        m_req = 2'b01;
        for (int c = 0; c < 10; c++) begin s_rvalid = (q.size() > 0); step(); end
        m_req = 2'b10;
        for (int c = 0; c < 3; c++) begin s_rvalid = (q.size() > 0); step(); end
        chk("perf_m0", perf_cnt[0], 32'd10);
        chk("perf_m1", perf_cnt[1], 32'd3);
        m_req = '0; s_gnt = 0; s_rvalid = (q.size() > 0);
        perf_clr = 1;
        step();
        perf_clr = 0;
        chk("perf_clr0", perf_cnt[0], 32'd0);
        chk("perf_clr1", perf_cnt[1], 32'd0);
        while (q.size() > 0) begin s_rvalid = 1; step(); end
        idle_inputs();
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            m_req = NB'($urandom);
            if (lock && $urandom_range(0, 9) != 0) m_req[lidx] = 1'b1;
            for (int i = 0; i < NB; i++) begin
                m_addr[i]  = $urandom;
                m_we[i]    = 1'($urandom);
                m_be[i]    = 4'($urandom);
                m_wdata[i] = $urandom;
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            s_rdata  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
